knight_rider_fader: RTL and testbench
=====================================

KNIGHT_RIDER_FADER -- requirements
Module: knight_rider_fader

Interface
REQ-001 Parameter PWM_W, default 4: brightness level width and PWM counter width; legal range 2..8.
REQ-002 Parameter DECAY_SHIFT, default 1: right-shift applied to non-lit LED levels per step; legal range 1..PWM_W.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 sys_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 pos_i  input  8  ring-counter position pattern (upstream ring counter output), nominally one-hot.
REQ-006 step_i  input  1  one-cycle strobe: pos_i has just advanced; sample pos_i this cycle.
REQ-007 led_o  output  8  registered PWM drive, one bit per LED, bit i follows pos_i bit i.
REQ-008 err_o  output  1  sticky flag: step_i seen with non-one-hot pos_i.

Function
REQ-009 Block SHALL hold eight PWM_W-bit brightness registers level[0..7].
REQ-010 Block SHALL hold one free-running PWM_W-bit counter pwm_cnt, incrementing every clock, wrapping from 2^PWM_W-1 to 0.
REQ-011 On a clock edge with step_i=1 and an accepted pos_i: level[i] SHALL load 2^PWM_W-1 where pos_i[i]=1; otherwise level[i] SHALL load level[i] >> DECAY_SHIFT.
REQ-012 With step_i=0: level[] SHALL hold.
REQ-013 Decay SHALL saturate at 0: a level of 0 stays 0; no underflow or wrap.
REQ-014 A lit position already at max SHALL stay at max; no overflow.
REQ-015 led_o[i] SHALL be registered as (level[i] > pwm_cnt), evaluated on pre-edge register values; one-cycle latency.
REQ-016 Effective duty SHALL be level[i] / 2^PWM_W: level 0 = always off; max = 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-017 A step_i edge SHALL NOT reset or perturb pwm_cnt.
REQ-018 step_i held high on consecutive cycles SHALL be treated as one step per cycle.

Reset
REQ-019 sys_rst_n_i low SHALL immediately clear, without a clock edge: level[]=0, pwm_cnt=0, led_o=8'h00, err_o=0.
REQ-020 Reset asserted mid-PWM period or mid-step SHALL discard all in-flight state.
REQ-021 First update after deassertion SHALL occur at the first rising edge with sys_rst_n_i high.

Configuration
REQ-022 Macro KNIGHT_RIDER_FADER_ONEHOT_CHECK_EN defined: a step with pos_i not exactly one-hot (including 8'h00) SHALL be rejected; level[] holds; err_o set to 1 at that edge and held until reset.
REQ-023 Macro undefined: every step SHALL be accepted per REQ-011 (all set bits light, all-zero pos_i decays all); err_o tied 0.
REQ-024 Both macro states SHALL leave the PWM path (REQ-010, REQ-015) unchanged.

Verification (PWM_W=4, DECAY_SHIFT=1)
REQ-025 Assert sys_rst_n_i low between clock edges -> led_o=00, err_o=0 immediately; hold 20 cycles, no toggling.
REQ-026 pos_i=8'h01, one step_i pulse, then 64 idle cycles -> led_o[0] high exactly 15 of every 16 cycles; led_o[7:1]=0.
REQ-027 Steps with pos_i=01,02,04 on three consecutive cycles -> level[2]=15, level[1]=7, level[0]=3; measured duties 15/16, 7/16, 3/16.
REQ-028 Five further steps with pos_i=8'h04 -> level[1] sequence 3,1,0,0,0; level[2] stays 15; no wrap.
REQ-029 Step with pos_i=8'h03 -> with macro: err_o=1, levels unchanged, err_o holds after valid steps; without macro: level[0]=level[1]=15, err_o=0.
REQ-030 Full 16-step Knight Rider bounce 01..80..01, one step per 8 clocks -> led_o trail of head plus decaying neighbours matches model each cycle; release from mid-sequence async reset restarts from all-zero.

Source files
------------

// File: rtl/knight_rider_fader.sv
// rtl/knight_rider_fader.sv - PWM fader: eight decaying brightness levels driven by a ring-counter position.
// Optional KNIGHT_RIDER_FADER_ONEHOT_CHECK_EN rejects non-one-hot steps and raises a sticky err_o.
module knight_rider_fader #(
    parameter int PWM_W       = 4,
    parameter int DECAY_SHIFT = 1
) (
    input  logic       clk_i,
    input  logic       sys_rst_n_i,
    input  logic [7:0] pos_i,
    input  logic       step_i,
    output logic [7:0] led_o,
    output logic       err_o
);

    localparam logic [PWM_W-1:0] LVL_MAX = '1;

    logic [PWM_W-1:0] level_q [8];
    logic [PWM_W-1:0] level_d [8];
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       led_q, led_d;
    logic             err_q, err_d;
    logic             accept;

`ifdef KNIGHT_RIDER_FADER_ONEHOT_CHECK_EN
    logic one_hot;
    assign one_hot = (pos_i != 8'h00) && ((pos_i & (pos_i - 8'd1)) == 8'h00);
    assign accept  = one_hot;
    assign err_d   = err_q | (step_i & ~one_hot);
`else
    assign accept  = 1'b1;
    assign err_d   = 1'b0;
`endif

    // Lit positions load full scale; all others decay, bottoming out at zero by the shift itself.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        for (int i = 0; i < 8; i++) begin
            level_d[i] = level_q[i];
            if (step_i && accept) begin
                level_d[i] = pos_i[i] ? LVL_MAX : (level_q[i] >> DECAY_SHIFT);
            end
            led_d[i] = (level_q[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= '0;
            end
            pwm_cnt_q <= '0;
            led_q     <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                level_q[i] <= level_d[i];
            end
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
            err_q     <= err_d;
        end
    end

    assign led_o = led_q;
    assign err_o = err_q;

endmodule

// File: tb/tb_knight_rider_fader.sv
// tb/tb_knight_rider_fader.sv - directed and randomized checks of knight_rider_fader against an integer model.
module tb_knight_rider_fader;

    localparam int PW   = 4;
    localparam int DS   = 1;
    localparam int MAXL = (1 << PW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pos = 8'h00;
    logic       step = 1'b0;
    logic [7:0] led;
    logic       err;

    int         lvl [8];
    int         cnt;
    logic [7:0] exp_led;
    logic       exp_err;
    int         vectors = 0;
    int         miscompares = 0;
    int         duty [8];

    knight_rider_fader #(.PWM_W(PW), .DECAY_SHIFT(DS)) dut (
        .clk_i      (clk),
        .sys_rst_n_i(rst_n),
        .pos_i      (pos),
        .step_i     (step),
        .led_o      (led),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) lvl[i] = 0;
        cnt     = 0;
        exp_led = 8'h00;
        exp_err = 1'b0;
    endtask

    function automatic bit step_ok(input logic [7:0] p);
`ifdef KNIGHT_RIDER_FADER_ONEHOT_CHECK_EN
        return $countones(p) == 1;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: present inputs, advance the model at the edge, compare 1 time unit later.
    task automatic tick(input logic st, input logic [7:0] p, input string tag);
        step = st;
        pos  = p;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < 8; i++) exp_led[i] = (lvl[i] > cnt);
            if (st && step_ok(p)) begin
                for (int i = 0; i < 8; i++) lvl[i] = p[i] ? MAXL : (lvl[i] >> DS);
            end
            if (st && !step_ok(p)) exp_err = 1'b1;
            cnt = (cnt + 1) % (1 << PW);
        end
        #1;
        chk({tag, "_led"}, int'(led), int'(exp_led));
        chk({tag, "_err"}, int'(err), int'(exp_err));
        for (int i = 0; i < 8; i++) duty[i] += int'(led[i]);
    endtask

    task automatic clear_duty();
        for (int i = 0; i < 8; i++) duty[i] = 0;
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk({tag, "_async_led"}, int'(led), 0);
        chk({tag, "_async_err"}, int'(err), 0);
    endtask

    initial begin
        model_reset();
        clear_duty();
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, "por");
        rst_n = 1'b1;

        tick(1'b1, 8'h81, "prime");
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, "prime_idle");
        async_reset("rst");
        for (int i = 0; i < 20; i++) tick(1'b0, 8'h00, "rst_hold");
        rst_n = 1'b1;

        // Single lit LED: 15 of 16 cycles on, everything else dark.
        tick(1'b1, 8'h01, "single");
        clear_duty();
        for (int i = 0; i < 64; i++) tick(1'b0, 8'h00, "single_idle");
        chk("single_duty0", duty[0], 60);
        chk("single_duty_rest", duty[1] + duty[2] + duty[3] + duty[4] + duty[5] + duty[6] + duty[7], 0);

        tick(1'b1, 8'h01, "trail");
        tick(1'b1, 8'h02, "trail");
        tick(1'b1, 8'h04, "trail");
        clear_duty();
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, "trail_idle");
        chk("trail_duty2", duty[2], 15);
        chk("trail_duty1", duty[1], 7);
        chk("trail_duty0", duty[0], 3);

        // Repeated steps on the same head: neighbours decay to 0 and stay there.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h04, "decay");
        clear_duty();
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, "decay_idle");
        chk("decay_duty2", duty[2], 15);
        chk("decay_duty1", duty[1], 0);
        chk("decay_duty0", duty[0], 0);

        tick(1'b1, 8'h03, "multi");
        clear_duty();
        for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, "multi_idle");
`ifdef KNIGHT_RIDER_FADER_ONEHOT_CHECK_EN
        chk("multi_err", int'(err), 1);
        chk("multi_duty2", duty[2], 15);
        chk("multi_duty0", duty[0], 0);
`else
        chk("multi_err", int'(err), 0);
        chk("multi_duty0", duty[0], 15);
        chk("multi_duty1", duty[1], 15);
`endif
        tick(1'b1, 8'h00, "zero_pos");
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h10, "valid_after");
        for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, "valid_after_idle");

        // Knight Rider bounce with a mid-sequence reset, then a clean full bounce.
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (k < 8) ? k : 15 - k;
            tick(1'b1, 8'(1 << idx), "bounce_a");
            for (int j = 0; j < 7; j++) tick(1'b0, 8'h00, "bounce_a_idle");
            if (k == 9) begin
                async_reset("bounce");
                for (int j = 0; j < 3; j++) tick(1'b1, 8'h20, "bounce_rst_hold");
                rst_n = 1'b1;
                break;
            end
        end
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (k < 8) ? k : 15 - k;
            tick(1'b1, 8'(1 << idx), "bounce_b");
            for (int j = 0; j < 7; j++) tick(1'b0, 8'h00, "bounce_b_idle");
        end

        for (int n = 0; n < 400; n++) begin
            logic       st;
            logic [7:0] p;
            st = ($urandom_range(0, 2) == 0);
            p  = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'(1 << $urandom_range(0, 7));
            tick(st, p, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
